// File: rtl/fetch_stage.sv
// Fetch stage: holds the fetch PC, issues one aligned block request at a time
// to the I-cache, and pushes up to PUSH_WIDTH instructions per cycle into the
// instruction buffer. Prediction is sequential only (NPC = PC + 4).
//
// new_ib_entry packs PUSH_WIDTH entries of 97 bits each. Entry i occupies
// bits [97*i+96 : 97*i], laid out as {inst[31:0], pc[31:0], npc[31:0], valid}.
module fetch_stage #(
    parameter int          PUSH_WIDTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [31:0]                       redirect_pc,
    input  logic [$clog2(PUSH_WIDTH+1)-1:0]   available_slots,
    output logic                              icache_req_valid,
    output logic [31:0]                       icache_req_addr,
    input  logic                              icache_req_ready,
    input  logic                              icache_resp_valid,
    input  logic [32*PUSH_WIDTH-1:0]          icache_resp_data,
    output logic [$clog2(PUSH_WIDTH+1)-1:0]   num_pushes,
    output logic [97*PUSH_WIDTH-1:0]          new_ib_entry,
    output logic [31:0]                       fetch_pc
);

    localparam int CW      = $clog2(PUSH_WIDTH + 1);
    localparam int IW      = $clog2(PUSH_WIDTH);
    localparam int ENTRY_W = 97;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DELIVER,
        DROP
    } state_t;

    state_t                       state;
    logic [31:0]                  pc;
    logic [PUSH_WIDTH-1:0][31:0]  block;

    logic [IW-1:0]                idx;
    logic [CW-1:0]                remaining;
    logic [CW-1:0]                push_count;
    logic                         deliver_active;

    // Work out how many instructions can leave the held block this cycle
    always_comb begin
        idx            = pc[IW+1:2];
        remaining      = CW'(PUSH_WIDTH) - CW'(idx);
        push_count     = (available_slots < remaining) ? available_slots : remaining;
        deliver_active = (state == DELIVER) && !flush && !reset;
    end

    // Drive request and push outputs; flush and reset suppress every handshake
    always_comb begin
        icache_req_valid = (state == REQ) && !flush && !reset;
        icache_req_addr  = {pc[31:IW+2], {(IW+2){1'b0}}};
        num_pushes       = deliver_active ? push_count : '0;
        fetch_pc         = pc;
        new_ib_entry     = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (deliver_active && (CW'(i) < push_count)) begin
                new_ib_entry[ENTRY_W*i +: ENTRY_W] = {block[idx + IW'(i)],
                                                      pc + 32'(4*i),
                                                      pc + 32'(4*i) + 32'd4,
                                                      1'b1};
            end
        end
    end

    // Sequence requests, responses and deliveries; flush overrides everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
            block <= '0;
        end else if (flush) begin
            pc <= redirect_pc;
            unique case (state)
                WAIT:    state <= icache_resp_valid ? REQ : DROP;
                DROP:    state <= icache_resp_valid ? REQ : DROP;
                default: state <= REQ;
            endcase
        end else begin
            unique case (state)
                REQ: begin
                    if (icache_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (icache_resp_valid) begin
                        block <= icache_resp_data;
                        state <= DELIVER;
                    end
                end
                DELIVER: begin
                    pc <= pc + 32'({push_count, 2'b00});
                    if (push_count == remaining) begin
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (icache_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch front end.
module tb_fetch_stage;

    localparam int PW = 4;
    localparam int EW = 97;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic [2:0]        available_slots;
    logic              icache_req_valid;
    logic [31:0]       icache_req_addr;
    logic              icache_req_ready;
    logic              icache_resp_valid;
    logic [32*PW-1:0]  icache_resp_data;
    logic [2:0]        num_pushes;
    logic [EW*PW-1:0]  new_ib_entry;
    logic [31:0]       fetch_pc;

    int checks_total  = 0;
    int checks_passed = 0;

    fetch_stage #(.PUSH_WIDTH(PW), .RESET_PC(32'h0)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .available_slots   (available_slots),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .num_pushes        (num_pushes),
        .new_ib_entry      (new_ib_entry),
        .fetch_pc          (fetch_pc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset             = 1'b1;
        flush             = 1'b0;
        redirect_pc       = 32'h0;
        available_slots   = 3'd0;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Expected pushed entries: n sequential instructions taken from blk starting at start_pc
    function automatic logic [EW*PW-1:0] expect_entries(input logic [32*PW-1:0] blk,
                                                         input logic [31:0] start_pc,
                                                         input int n);
        logic [EW*PW-1:0] v;
        logic [31:0]      p;
        int               first;
        v     = '0;
        first = int'(start_pc[3:2]);
        for (int i = 0; i < n; i++) begin
            p = start_pc + 32'(4*i);
            v[EW*i +: EW] = {blk[32*(first+i) +: 32], p, p + 32'd4, 1'b1};
        end
        return v;
    endfunction

    task automatic test_reset;
        reset             = 1'b1;
        flush             = 1'b0;
        redirect_pc       = 32'h0;
        available_slots   = 3'd4;
        icache_req_ready  = 1'b1;
        icache_resp_valid = 1'b0;
        icache_resp_data  = '0;
        tick;
        tick;
        checks_total++;
        if (icache_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b want 0", icache_req_valid);
        else checks_passed++;
        checks_total++;
        if (num_pushes !== 3'd0) $display("[TB] FAIL reset_num_pushes: got %0d want 0", num_pushes);
        else checks_passed++;
        checks_total++;
        if (new_ib_entry !== '0) $display("[TB] FAIL reset_entries: got %h want 0", new_ib_entry);
        else checks_passed++;
        reset            = 1'b0;
        icache_req_ready = 1'b0;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0)
            $display("[TB] FAIL post_reset_req: got valid=%b addr=%h want valid=1 addr=00000000", icache_req_valid, icache_req_addr);
        else checks_passed++;
        checks_total++;
        if (fetch_pc !== 32'h0) $display("[TB] FAIL post_reset_pc: got %h want 00000000", fetch_pc);
        else checks_passed++;
    endtask

    task automatic test_aligned_block;
        logic [127:0] blk;
        blk = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        do_reset;
        icache_req_ready = 1'b1;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0)
            $display("[TB] FAIL block_req: got valid=%b addr=%h want valid=1 addr=00000000", icache_req_valid, icache_req_addr);
        else checks_passed++;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = blk;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b0) $display("[TB] FAIL wait_no_req: got %b want 0", icache_req_valid);
        else checks_passed++;
        tick;
        icache_resp_valid = 1'b0;
        available_slots   = 3'd4;
        #1;
        checks_total++;
        if (num_pushes !== 3'd4) $display("[TB] FAIL block_pushes: got %0d want 4", num_pushes);
        else checks_passed++;
        checks_total++;
        if (new_ib_entry !== expect_entries(blk, 32'h0, 4))
            $display("[TB] FAIL block_entries: got %h want %h", new_ib_entry, expect_entries(blk, 32'h0, 4));
        else checks_passed++;
        tick;
        available_slots = 3'd0;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10)
            $display("[TB] FAIL next_block_req: got valid=%b addr=%h want valid=1 addr=00000010", icache_req_valid, icache_req_addr);
        else checks_passed++;
    endtask

    task automatic test_flush_deliver;
        logic [127:0] blk_a, blk_b;
        blk_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        blk_b = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        do_reset;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = blk_a;
        tick;
        icache_resp_valid = 1'b0;
        available_slots   = 3'd4;
        flush             = 1'b1;
        redirect_pc       = 32'h18;
        #1;
        checks_total++;
        if (num_pushes !== 3'd0 || icache_req_valid !== 1'b0)
            $display("[TB] FAIL flush_cycle_quiet: got pushes=%0d req_valid=%b want pushes=0 req_valid=0", num_pushes, icache_req_valid);
        else checks_passed++;
        tick;
        flush            = 1'b0;
        icache_req_ready = 1'b1;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10)
            $display("[TB] FAIL redirect_req: got valid=%b addr=%h want valid=1 addr=00000010", icache_req_valid, icache_req_addr);
        else checks_passed++;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = blk_b;
        tick;
        icache_resp_valid = 1'b0;
        #1;
        checks_total++;
        if (num_pushes !== 3'd2) $display("[TB] FAIL unaligned_pushes: got %0d want 2", num_pushes);
        else checks_passed++;
        checks_total++;
        if (new_ib_entry !== expect_entries(blk_b, 32'h18, 2))
            $display("[TB] FAIL unaligned_entries: got %h want %h", new_ib_entry, expect_entries(blk_b, 32'h18, 2));
        else checks_passed++;
        tick;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h20)
            $display("[TB] FAIL after_unaligned_req: got valid=%b addr=%h want valid=1 addr=00000020", icache_req_valid, icache_req_addr);
        else checks_passed++;
    endtask

    task automatic test_backpressure;
        logic [127:0] blk;
        blk = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        do_reset;
        flush       = 1'b1;
        redirect_pc = 32'h40;
        tick;
        flush            = 1'b0;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = blk;
        tick;
        icache_resp_valid = 1'b0;
        available_slots   = 3'd1;
        #1;
        checks_total++;
        if (num_pushes !== 3'd1 || new_ib_entry !== expect_entries(blk, 32'h40, 1))
            $display("[TB] FAIL bp_one: got pushes=%0d entries=%h want pushes=1 entries=%h", num_pushes, new_ib_entry, expect_entries(blk, 32'h40, 1));
        else checks_passed++;
        tick;
        available_slots = 3'd0;
        #1;
        checks_total++;
        if (num_pushes !== 3'd0 || fetch_pc !== 32'h44 || icache_req_valid !== 1'b0)
            $display("[TB] FAIL bp_zero: got pushes=%0d pc=%h req=%b want pushes=0 pc=00000044 req=0", num_pushes, fetch_pc, icache_req_valid);
        else checks_passed++;
        tick;
        available_slots = 3'd4;
        #1;
        checks_total++;
        if (num_pushes !== 3'd3 || new_ib_entry !== expect_entries(blk, 32'h44, 3))
            $display("[TB] FAIL bp_rest: got pushes=%0d entries=%h want pushes=3 entries=%h", num_pushes, new_ib_entry, expect_entries(blk, 32'h44, 3));
        else checks_passed++;
        checks_total++;
        if (icache_req_valid !== 1'b0) $display("[TB] FAIL bp_early_req: got %b want 0", icache_req_valid);
        else checks_passed++;
        tick;
        available_slots = 3'd0;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h50)
            $display("[TB] FAIL bp_next_req: got valid=%b addr=%h want valid=1 addr=00000050", icache_req_valid, icache_req_addr);
        else checks_passed++;
    endtask

    task automatic test_req_stall;
        logic [127:0] blk;
        blk = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        do_reset;
        flush       = 1'b1;
        redirect_pc = 32'h10;
        tick;
        flush            = 1'b0;
        icache_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            icache_req_ready = (k == 3);
            #1;
            checks_total++;
            if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10)
                $display("[TB] FAIL stall_hold_%0d: got valid=%b addr=%h want valid=1 addr=00000010", k, icache_req_valid, icache_req_addr);
            else checks_passed++;
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks_total++;
            if (icache_req_valid !== 1'b0) $display("[TB] FAIL stall_second_req_%0d: got %b want 0", k, icache_req_valid);
            else checks_passed++;
            tick;
        end
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = blk;
        tick;
        icache_resp_valid = 1'b0;
        available_slots   = 3'd4;
        #1;
        checks_total++;
        if (num_pushes !== 3'd4 || new_ib_entry !== expect_entries(blk, 32'h10, 4))
            $display("[TB] FAIL stall_delivery: got pushes=%0d entries=%h want pushes=4 entries=%h", num_pushes, new_ib_entry, expect_entries(blk, 32'h10, 4));
        else checks_passed++;
        tick;
        available_slots = 3'd0;
    endtask

    task automatic test_flush_wait;
        logic [127:0] stale, fresh;
        stale = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        fresh = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        do_reset;
        icache_req_ready = 1'b1;
        tick;
        flush       = 1'b1;
        redirect_pc = 32'h100;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b0) $display("[TB] FAIL wait_flush_req: got %b want 0", icache_req_valid);
        else checks_passed++;
        tick;
        flush           = 1'b0;
        available_slots = 3'd4;
        for (int k = 0; k < 3; k++) begin
            icache_resp_valid = (k == 2);
            icache_resp_data  = stale;
            #1;
            checks_total++;
            if (icache_req_valid !== 1'b0 || num_pushes !== 3'd0)
                $display("[TB] FAIL drop_quiet_%0d: got req=%b pushes=%0d want req=0 pushes=0", k, icache_req_valid, num_pushes);
            else checks_passed++;
            tick;
        end
        icache_resp_valid = 1'b0;
        icache_req_ready  = 1'b0;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100 || fetch_pc !== 32'h100)
            $display("[TB] FAIL drop_then_req: got valid=%b addr=%h pc=%h want valid=1 addr=00000100 pc=00000100", icache_req_valid, icache_req_addr, fetch_pc);
        else checks_passed++;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = fresh;
        tick;
        icache_resp_valid = 1'b0;
        #1;
        checks_total++;
        if (new_ib_entry !== expect_entries(fresh, 32'h100, 4))
            $display("[TB] FAIL drop_fresh_data: got %h want %h", new_ib_entry, expect_entries(fresh, 32'h100, 4));
        else checks_passed++;
        tick;
        available_slots = 3'd0;
    endtask

    task automatic test_flush_with_resp;
        logic [127:0] stale, fresh;
        stale = {32'h53, 32'h52, 32'h51, 32'h50};
        fresh = {32'h63, 32'h62, 32'h61, 32'h60};
        do_reset;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready  = 1'b0;
        flush             = 1'b1;
        redirect_pc       = 32'h204;
        icache_resp_valid = 1'b1;
        icache_resp_data  = stale;
        available_slots   = 3'd4;
        #1;
        checks_total++;
        if (num_pushes !== 3'd0 || icache_req_valid !== 1'b0)
            $display("[TB] FAIL coincident_quiet: got pushes=%0d req=%b want pushes=0 req=0", num_pushes, icache_req_valid);
        else checks_passed++;
        tick;
        flush             = 1'b0;
        icache_resp_valid = 1'b0;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h200)
            $display("[TB] FAIL coincident_req: got valid=%b addr=%h want valid=1 addr=00000200", icache_req_valid, icache_req_addr);
        else checks_passed++;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = fresh;
        tick;
        icache_resp_valid = 1'b0;
        #1;
        checks_total++;
        if (num_pushes !== 3'd3 || new_ib_entry !== expect_entries(fresh, 32'h204, 3))
            $display("[TB] FAIL coincident_delivery: got pushes=%0d entries=%h want pushes=3 entries=%h", num_pushes, new_ib_entry, expect_entries(fresh, 32'h204, 3));
        else checks_passed++;
        tick;
        #1;
        checks_total++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h210)
            $display("[TB] FAIL coincident_next_req: got valid=%b addr=%h want valid=1 addr=00000210", icache_req_valid, icache_req_addr);
        else checks_passed++;
        available_slots = 3'd0;
    endtask

    // Randomized run against a model that tracks only the fetch PC, whether a
    // request is outstanding, whether that response is already stale, and the
    // block currently being drained.
    task automatic test_random;
        logic [31:0]      m_pc;
        bit               m_out, m_stale, m_have, got, exp_rv;
        logic [127:0]     m_blk;
        logic [EW*PW-1:0] exp_e;
        int               exp_n, room;
        do_reset;
        m_pc    = 32'h0;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_have  = 1'b0;
        m_blk   = '0;
        room    = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            flush             = ($urandom_range(0, 19) == 0);
            redirect_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF4 + 32'($urandom_range(0, 2) * 4)
                                                           : ($urandom & 32'hFFFF_FFFC);
            available_slots   = 3'($urandom_range(0, 4));
            icache_req_ready  = 1'($urandom_range(0, 1));
            icache_resp_valid = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            icache_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            exp_rv = 1'b0;
            exp_n  = 0;
            exp_e  = '0;
            if (!flush) begin
                if (m_have) begin
                    room  = PW - int'(m_pc[3:2]);
                    exp_n = (int'(available_slots) < room) ? int'(available_slots) : room;
                    exp_e = expect_entries(m_blk, m_pc, exp_n);
                end else if (!m_out) begin
                    exp_rv = 1'b1;
                end
            end
            #1;
            checks_total++;
            if (icache_req_valid !== exp_rv)
                $display("[TB] FAIL rand_req_valid cyc %0d: got %b want %b", cyc, icache_req_valid, exp_rv);
            else checks_passed++;
            if (exp_rv) begin
                checks_total++;
                if (icache_req_addr !== {m_pc[31:4], 4'b0})
                    $display("[TB] FAIL rand_req_addr cyc %0d: got %h want %h", cyc, icache_req_addr, {m_pc[31:4], 4'b0});
                else checks_passed++;
            end
            checks_total++;
            if (num_pushes !== 3'(exp_n) || new_ib_entry !== exp_e)
                $display("[TB] FAIL rand_push cyc %0d: got n=%0d e=%h want n=%0d e=%h", cyc, num_pushes, new_ib_entry, exp_n, exp_e);
            else checks_passed++;
            checks_total++;
            if (fetch_pc !== m_pc) $display("[TB] FAIL rand_fetch_pc cyc %0d: got %h want %h", cyc, fetch_pc, m_pc);
            else checks_passed++;
            got = icache_resp_valid && m_out;
            if (flush) begin
                m_pc    = redirect_pc;
                m_have  = 1'b0;
                m_stale = m_out && !icache_resp_valid;
                m_out   = m_out && !icache_resp_valid;
            end else begin
                if (m_have) begin
                    m_pc = m_pc + 32'(4 * exp_n);
                    if (exp_n == room) m_have = 1'b0;
                end
                if (got) begin
                    m_out = 1'b0;
                    if (m_stale) m_stale = 1'b0;
                    else begin
                        m_blk  = icache_resp_data;
                        m_have = 1'b1;
                    end
                end
                if (exp_rv && icache_req_ready) m_out = 1'b1;
            end
            tick;
        end
        flush             = 1'b0;
        icache_resp_valid = 1'b0;
        icache_req_ready  = 1'b0;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset;
        test_aligned_block;
        test_flush_deliver;
        test_backpressure;
        test_req_stall;
        test_flush_wait;
        test_flush_with_resp;
        test_random;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
